// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding, frame width and mode-0 constants,
// used by both spi_master and spi_slave.
package spi_pkg;

    localparam int   SPI_WIDTH = 8;
    localparam logic SPI_CPOL  = 1'b0;
    localparam logic SPI_CPHA  = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SETUP     = 3'd1,
        ST_SCK_HIGH  = 3'd2,
        ST_SCK_LOW   = 3'd3,
        ST_WAIT_NEXT = 3'd4,
        ST_GAP       = 3'd5
    } spi_state_t;

    // Slave select is held low from setup through a burst hold.
    function automatic logic ss_active(input spi_state_t st);
        case (st)
            ST_SETUP, ST_SCK_HIGH, ST_SCK_LOW, ST_WAIT_NEXT: ss_active = 1'b1;
            default:                                         ss_active = 1'b0;
        endcase
    endfunction

    // Busy covers every state in which a new start must be refused.
    function automatic logic busy_state(input spi_state_t st);
        case (st)
            ST_SETUP, ST_SCK_HIGH, ST_SCK_LOW, ST_GAP: busy_state = 1'b1;
            default:                                   busy_state = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// Half-period timer for the SPI master: counts 0..CLK_DIV-1 and flags the
// last cycle of each phase. Held at zero while the master is parked.
module spi_sck_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    logic [7:0] cnt_r;
    logic       wrap_s;

    assign wrap_s = (cnt_r == 8'(CLK_DIV - 1));
    assign tick   = wrap_s && !clear;

    // Phase counter, restarted whenever the master is idle or waiting.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= 8'd0;
        end else if (clear || wrap_s) begin
            cnt_r <= 8'd0;
        end else begin
            cnt_r <= cnt_r + 8'd1;
        end
    end

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master: one byte per start, MSB first, with an optional ss hold
// that lets a follow-on byte skip the setup phase.
module spi_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [SPI_WIDTH-1:0] din,
    input  logic                 hold_ss,
    output logic [SPI_WIDTH-1:0] dout,
    output logic                 done,
    output logic                 busy,
    output logic                 ss,
    output logic                 sck,
    output logic                 mosi,
    input  logic                 miso
);

    localparam logic [3:0] LAST_HIGH = 4'(SPI_WIDTH - 1);
    localparam logic [3:0] ALL_HIGHS = 4'(SPI_WIDTH);

    spi_state_t           state_r;
    spi_state_t           state_next_s;
    logic                 tick_s;
    logic                 clear_s;
    logic                 load_s;
    logic                 shift_s;
    logic                 end_byte_s;
    logic                 sample_lead_s;
    logic [SPI_WIDTH-2:0] tx_r;
    logic [SPI_WIDTH-1:0] rx_r;
    logic [3:0]           hi_cnt_r;
    logic                 hold_r;
    logic                 burst_r;
    logic                 sample_pend_r;
    logic                 miso_r;
    logic [SPI_WIDTH-1:0] dout_r;
    logic                 done_r;
    logic                 busy_r;
    logic                 ss_r;
    logic                 sck_r;
    logic                 mosi_r;

    assign clear_s = (state_r == ST_IDLE) || (state_r == ST_WAIT_NEXT);

    spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
        .clk   (clk),
        .rst   (rst),
        .clear (clear_s),
        .tick  (tick_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic. A byte started from IDLE is setup + 8 high/low pairs;
    // a burst byte is 8 low/high pairs, so it ends after its 8th high phase.
    always_comb begin
        state_next_s = state_r;
        load_s       = 1'b0;
        shift_s      = 1'b0;
        end_byte_s   = 1'b0;
        case (state_r)
            ST_IDLE, ST_WAIT_NEXT: begin
                if (start) begin
                    load_s       = 1'b1;
                    state_next_s = (state_r == ST_WAIT_NEXT) ? ST_SCK_LOW : ST_SETUP;
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_SETUP: begin
                if (tick_s) begin
                    state_next_s = ST_SCK_HIGH;
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_SCK_HIGH: begin
                if (!tick_s) begin
                    state_next_s = state_r;
                end else if (hi_cnt_r != LAST_HIGH) begin
                    shift_s      = 1'b1;
                    state_next_s = ST_SCK_LOW;
                end else if (burst_r) begin
                    end_byte_s   = 1'b1;
                    state_next_s = hold_r ? ST_WAIT_NEXT : ST_GAP;
                end else begin
                    state_next_s = ST_SCK_LOW;
                end
            end
            ST_SCK_LOW: begin
                if (!tick_s) begin
                    state_next_s = state_r;
                end else if (hi_cnt_r == ALL_HIGHS) begin
                    end_byte_s   = 1'b1;
                    state_next_s = hold_r ? ST_WAIT_NEXT : ST_GAP;
                end else begin
                    state_next_s = ST_SCK_HIGH;
                end
            end
            ST_GAP: begin
                if (tick_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = state_r;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Mode 0 samples on the leading (rising) edge of sck.
    assign sample_lead_s = (state_next_s == ST_SCK_HIGH) && (state_r != ST_SCK_HIGH)
                           && (SPI_CPHA == 1'b0);

    // Datapath and registered pins; pin values follow the next state so they
    // change on the same edge as the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_r          <= '0;
            rx_r          <= '0;
            hi_cnt_r      <= 4'd0;
            hold_r        <= 1'b0;
            burst_r       <= 1'b0;
            sample_pend_r <= 1'b0;
            miso_r        <= 1'b0;
            dout_r        <= '0;
            done_r        <= 1'b0;
            busy_r        <= 1'b0;
            ss_r          <= 1'b1;
            sck_r         <= SPI_CPOL;
            mosi_r        <= 1'b0;
        end else begin
            miso_r        <= miso;
            done_r        <= end_byte_s;
            ss_r          <= ~ss_active(state_next_s);
            busy_r        <= busy_state(state_next_s);
            sck_r         <= (state_next_s == ST_SCK_HIGH) ? ~SPI_CPOL : SPI_CPOL;
            sample_pend_r <= sample_lead_s;
            // miso_r here holds the line as it was at the sck rising edge
            if (sample_pend_r) begin
                rx_r <= {rx_r[SPI_WIDTH-2:0], miso_r};
            end else begin
                rx_r <= rx_r;
            end
            if (end_byte_s) begin
                dout_r <= rx_r;
            end else begin
                dout_r <= dout_r;
            end
            if (load_s) begin
                tx_r     <= din[SPI_WIDTH-2:0];
                mosi_r   <= din[SPI_WIDTH-1];
                hold_r   <= hold_ss;
                burst_r  <= (state_r == ST_WAIT_NEXT);
                hi_cnt_r <= 4'd0;
            end else if (shift_s) begin
                mosi_r   <= tx_r[SPI_WIDTH-2];
                tx_r     <= {tx_r[SPI_WIDTH-3:0], 1'b0};
                hi_cnt_r <= hi_cnt_r + 4'd1;
            end else if (state_r == ST_SCK_HIGH && tick_s) begin
                hi_cnt_r <= hi_cnt_r + 4'd1;
            end else begin
                hi_cnt_r <= hi_cnt_r;
            end
        end
    end

    assign dout = dout_r;
    assign done = done_r;
    assign busy = busy_r;
    assign ss   = ss_r;
    assign sck  = sck_r;
    assign mosi = mosi_r;

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter CLK_DIV, default 4, sets the sck half-period in clk cycles; legal range 2..255.
REQ-002 clk  input  1  single system clock; all logic on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  one-cycle request to transfer din; honoured only when busy=0.
REQ-005 din  input  8  byte to transmit; sampled in the cycle start is honoured.
REQ-006 hold_ss  input  1  sampled with start; 1 keeps ss low after the byte for a burst.
REQ-007 dout  output  8  byte received on miso; valid from the done cycle until the next done.
REQ-008 done  output  1  one-cycle pulse when a byte completes.
REQ-009 busy  output  1  high from the cycle after an honoured start until ready for the next start.
REQ-010 ss  output  1  active-low slave select.
REQ-011 sck  output  1  serial clock, mode 0 (CPOL=0, CPHA=0).
REQ-012 mosi  output  1  serial data out, MSB first.
REQ-013 miso  input  1  serial data in, MSB first; registered before use.

Function
REQ-014 The FSM SHALL have states IDLE, SETUP, SCK_HIGH, SCK_LOW, WAIT_NEXT and GAP.
REQ-015 IDLE + start: latch din and hold_ss, drive ss=0, drive mosi=din[7], busy=1, enter SETUP.
REQ-016 SETUP: keep sck=0 for CLK_DIV cycles, then enter SCK_HIGH.
REQ-017 SCK_HIGH: drive sck=1 for CLK_DIV cycles; sample the registered miso into the LSB of the receive shifter on the entry cycle.
REQ-018 SCK_LOW: drive sck=0 for CLK_DIV cycles; at entry, shift the next bit onto mosi (bits 1..7 only); after 8 high/low pairs, end the byte.
REQ-019 Byte end: dout=received byte and done=1 in the cycle after the 8th SCK_LOW ends, i.e. exactly 1+17*CLK_DIV cycles after the start cycle.
REQ-020 Byte end with latched hold_ss=0: enter GAP with ss=1, sck=0, busy=1 for CLK_DIV cycles, then IDLE with busy=0.
REQ-021 Byte end with latched hold_ss=1: enter WAIT_NEXT with ss=0, sck=0, busy=0.
REQ-022 WAIT_NEXT + start: load the new byte, drive mosi=din[7], and go directly to SCK_LOW for CLK_DIV cycles (no SETUP); its done occurs 1+16*CLK_DIV cycles after that start.
REQ-023 WAIT_NEXT + rst_ss-free release: a start with hold_ss=0 SHALL end the burst after that byte per REQ-020.
REQ-024 start while busy=1 SHALL be ignored, with no effect on data or state.
REQ-025 done and start in the same cycle (WAIT_NEXT or IDLE entry) SHALL NOT be honoured until busy=0 is visible; start is honoured only in IDLE or WAIT_NEXT.
REQ-026 sck SHALL be glitch-free: registered outputs only, no combinational path from start to ss, sck or mosi.
REQ-027 mosi SHALL be stable for at least CLK_DIV cycles before every sck rising edge.
REQ-028 The half-period counter SHALL count 0..CLK_DIV-1 and wrap; no other counter may overflow.

Reset
REQ-029 rst SHALL take priority over start in the same cycle.
REQ-030 After rst: state=IDLE, ss=1, sck=0, mosi=0, busy=0, done=0, dout=8'h00, shifters and counters cleared.
REQ-031 rst mid-transfer SHALL abort on the next edge with no done pulse; ss returns high and sck returns low in that same edge.

Structure
REQ-032 Shared package spi_pkg SHALL hold the FSM state encodings, SPI_WIDTH=8 and the mode-0 constants, for reuse by spi_slave.
REQ-033 One sub-module, spi_sck_gen, SHALL hold the half-period counter and emit a one-cycle phase-end tick; the FSM and shifters stay in spi_master.

Verification
REQ-034 Reset: assert rst for 2 cycles mid-idle -> ss=1, sck=0, mosi=0, busy=0, done=0, dout=0x00.
REQ-035 CLK_DIV=4, start with din=0xA5, slave model returns 0x3C -> mosi at the 8 rising edges is 1,0,1,0,0,1,0,1; done at cycle 69; dout=0x3C; ss high for 4 cycles, then busy=0.
REQ-036 Burst: hold_ss=1 with 0x12, then hold_ss=0 with 0x34 -> ss low continuously across both bytes; second done 65 cycles after its start; ss high after the second byte.
REQ-037 start pulsed at cycle 10 of a busy transfer with din=0xFF -> ignored; dout and mosi sequence unchanged.
REQ-038 rst asserted during the 4th SCK_HIGH -> next cycle ss=1, sck=0, no done; a fresh start with 0x81 then completes normally.
REQ-039 Loopback to the codebase's spi_slave: master sends 0x5A, slave din=0xC3 -> slave dout=0x5A and slave done pulses; master dout=0xC3.
